uart_alu_interface: RTL

// - Sits directly downstream of the UART receiver; consumes its o_data/o_valid byte stream.
// - Assembles three consecutive bytes (operand A, operand B, opcode) and drives them to the ALU.
// - Captures the ALU result and hands it to the UART transmitter with a start/done handshake.
// - Hides the serial framing from the ALU, closing the loop rx -> ALU -> tx.

---
 rtl/uart_alu_interface_pkg.sv | 27 ++
 rtl/uart_alu_interface_rx_valid_edge_detect.sv | 29 ++
 rtl/uart_alu_interface.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_alu_interface_pkg.sv
// ============================================================================
// Module : uart_alu_interface_pkg
// Brief  : Shared widths, one-hot FSM encoding and ALU opcodes for the UART/ALU bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_alu_interface_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;

  typedef enum logic [4:0] {
    ST_WAIT_A  = 5'b00001,
    ST_WAIT_B  = 5'b00010,
    ST_WAIT_OP = 5'b00100,
    ST_COMPUTE = 5'b01000,
    ST_WAIT_TX = 5'b10000
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_alu_interface_rx_valid_edge_detect.sv
// ============================================================================
// Module : rx_valid_edge_detect
// Brief  : One-cycle pulse on the rising edge of the receiver valid strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rx_valid_edge_detect (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_valid,
  output logic o_pulse
);

  logic valid_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_prev <= 1'b0;
    end else begin
      valid_prev <= i_valid;
    end
  end

  assign o_pulse = i_valid & ~valid_prev;

endmodule

`default_nettype wire

// File: rtl/uart_alu_interface.sv
// ============================================================================
// Module : uart_alu_interface
// Brief  : Collects A, B and opcode bytes from the UART receiver, feeds the ALU
//          and hands the result to the UART transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  state_t             state, next_state;
  logic               accept;
  logic [NB_DATA-1:0] next_alu_a, next_alu_b, next_tx_data;
  logic [NB_OP-1:0]   next_alu_op;
  logic               next_tx_start, next_busy, next_overrun;

  rx_valid_edge_detect u_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_rx_valid),
    .o_pulse   (accept)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= next_state;
      o_alu_a    <= next_alu_a;
      o_alu_b    <= next_alu_b;
      o_alu_op   <= next_alu_op;
      o_tx_data  <= next_tx_data;
      o_tx_start <= next_tx_start;
      o_busy     <= next_busy;
      o_overrun  <= next_overrun;
    end
  end

  always_comb begin
    next_state    = state;
    next_alu_a    = o_alu_a;
    next_alu_b    = o_alu_b;
    next_alu_op   = o_alu_op;
    next_tx_data  = o_tx_data;
    next_tx_start = 1'b0;
    next_overrun  = o_overrun;

    case (state)
      ST_WAIT_A: begin
        if (accept) begin
          next_alu_a = i_rx_data;
          next_state = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (accept) begin
          next_alu_b = i_rx_data;
          next_state = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (accept) begin
          next_alu_op = i_rx_data[NB_OP-1:0];
          next_state  = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        next_tx_data  = i_alu_result;
        next_tx_start = 1'b1;
        next_state    = ST_WAIT_TX;
        if (accept) next_overrun = 1'b1;
      end
      ST_WAIT_TX: begin
        // A byte arriving alongside tx_done is still dropped: we were not yet accepting.
        if (accept)    next_overrun = 1'b1;
        if (i_tx_done) next_state   = ST_WAIT_A;
      end
      default: next_state = ST_WAIT_A;
    endcase

    next_busy = (next_state == ST_COMPUTE) || (next_state == ST_WAIT_TX);
  end

endmodule

`default_nettype wire
